change_dispenser: RTL and testbench

//  Downstream of the vending FSM: takes the balance owed after a sale and pays it out as physical

---
 rtl/change_dispenser.sv | 191 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Pays out an owed balance as 20/10/5 coins through a
//                request/acknowledge hopper interface. Coins are chosen
//                greedily (largest first), empty hoppers are skipped, and
//                any unpaid amount is reported as shortfall. A hopper that
//                fails to acknowledge within ACK_TIMEOUT cycles aborts the
//                payout with fault set.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int WIDTH       = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [WIDTH-1:0] change_amt,
  input  logic             empty_20,
  input  logic             empty_10,
  input  logic             empty_5,
  input  logic             coin_ack,
  output logic             busy,
  output logic             coin_req,
  output logic [1:0]       coin_sel,
  output logic [WIDTH-1:0] remaining,
  output logic             done,
  output logic [WIDTH-1:0] shortfall,
  output logic             fault
);

  // Counter must be able to represent the full wait window.
  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  // The counter holds the number of unacknowledged REQ cycles already spent;
  // the cycle on which it equals this value is the last one allowed.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [WIDTH-1:0] C_VAL_20 = WIDTH'(20);
  localparam logic [WIDTH-1:0] C_VAL_10 = WIDTH'(10);
  localparam logic [WIDTH-1:0] C_VAL_5  = WIDTH'(5);

  localparam logic [1:0] C_SEL_5  = 2'b00;
  localparam logic [1:0] C_SEL_10 = 2'b01;
  localparam logic [1:0] C_SEL_20 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] shortfall_q, shortfall_d;
  logic [1:0]       sel_q, sel_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             req_q, req_d;
  logic             done_q, done_d;

  logic             pick_found;
  logic [1:0]       pick_sel;
  logic [WIDTH-1:0] coin_val;

  // Greedy coin choice from the current balance and hopper status.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = C_SEL_5;
    if ((remaining_q >= C_VAL_20) && !empty_20) begin
      pick_found = 1'b1;
      pick_sel   = C_SEL_20;
    end else if ((remaining_q >= C_VAL_10) && !empty_10) begin
      pick_found = 1'b1;
      pick_sel   = C_SEL_10;
    end else if ((remaining_q >= C_VAL_5) && !empty_5) begin
      pick_found = 1'b1;
      pick_sel   = C_SEL_5;
    end
  end

  // Face value of the coin currently being requested.
  always_comb begin
    coin_val = C_VAL_5;
    case (sel_q)
      C_SEL_20: coin_val = C_VAL_20;
      C_SEL_10: coin_val = C_VAL_10;
      default:  coin_val = C_VAL_5;
    endcase
  end

  // Next-state logic; output flags are decoded from the next state so they
  // leave the block straight from flops.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    sel_d       = sel_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (change_valid) begin
          remaining_d = change_amt;
          shortfall_d = '0;
          fault_d     = 1'b0;
          cnt_d       = '0;
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        if (pick_found) begin
          sel_d   = pick_sel;
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          // Nothing payable (covers a zero balance and non-multiples of 5).
          shortfall_d = remaining_q;
          state_d     = S_DONE;
        end
      end

      S_REQ: begin
        // An ack on the final allowed cycle still counts the coin.
        if (coin_ack) begin
          remaining_d = remaining_q - coin_val;
          cnt_d       = '0;
          state_d     = S_SELECT;
        end else if (cnt_q == C_CNT_LAST) begin
          fault_d     = 1'b1;
          shortfall_d = remaining_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    req_d  = (state_d == S_REQ);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      shortfall_q <= '0;
      sel_q       <= C_SEL_5;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      sel_q       <= sel_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign coin_req  = req_q;
  assign coin_sel  = sel_q;
  assign remaining = remaining_q;
  assign done      = done_q;
  assign shortfall = shortfall_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispenser
//  Description : Self-checking bench for change_dispenser against a
//                transaction-level greedy payout model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  localparam int WIDTH = 6;
  localparam int TO    = 15;
  localparam int NEVER = 40;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             change_valid = 1'b0;
  logic [WIDTH-1:0] change_amt = '0;
  logic             empty_20 = 1'b0;
  logic             empty_10 = 1'b0;
  logic             empty_5 = 1'b0;
  logic             coin_ack = 1'b0;
  logic             busy;
  logic             coin_req;
  logic [1:0]       coin_sel;
  logic [WIDTH-1:0] remaining;
  logic             done;
  logic [WIDTH-1:0] shortfall;
  logic             fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  change_dispenser #(
    .WIDTH       (WIDTH),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .empty_20     (empty_20),
    .empty_10     (empty_10),
    .empty_5      (empty_5),
    .coin_ack     (coin_ack),
    .busy         (busy),
    .coin_req     (coin_req),
    .coin_sel     (coin_sel),
    .remaining    (remaining),
    .done         (done),
    .shortfall    (shortfall),
    .fault        (fault)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_coin_req"},  coin_req,  0);
    check({tag, "_done"},      done,      0);
    check({tag, "_fault"},     fault,     0);
    check({tag, "_coin_sel"},  coin_sel,  0);
    check({tag, "_remaining"}, remaining, 0);
    check({tag, "_shortfall"}, shortfall, 0);
  endtask

  // mode: 0 = immediate ack, 1 = random delay (occasional dead hopper),
  //       2 = never ack, 3 = ack on the last allowed cycle
  task automatic run_txn(input int amt, input bit e20, input bit e10,
                         input bit e5, input int mode);
    int codes[$];
    int rems[$];
    int dly[$];
    int rem, exp_short, exp_lat, v, code, d, paid;
    bit exp_fault;
    int k, w, cnt;
    bit finished;

    // Reference: greedy payout over the available denominations.
    rem = amt; exp_lat = 0; exp_fault = 1'b0; paid = 0; exp_short = 0;
    while (1) begin
      code = 0;
      if (rem >= 20 && !e20) begin v = 20; code = 2; end
      else if (rem >= 10 && !e10) begin v = 10; code = 1; end
      else if (rem >= 5 && !e5) begin v = 5; code = 0; end
      else v = 0;
      if (v == 0) begin
        exp_short = rem;
        exp_lat  += 1;
        break;
      end
      case (mode)
        0:       d = 0;
        1:       d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
        2:       d = NEVER;
        default: d = TO - 1;
      endcase
      codes.push_back(code);
      rems.push_back(rem);
      dly.push_back(d);
      if (d >= TO) begin
        exp_fault = 1'b1;
        exp_short = rem;
        exp_lat  += 1 + TO;
        break;
      end
      rem     -= v;
      paid    += 1;
      exp_lat += 2 + d;
    end

    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = WIDTH'(amt);
    empty_20     = e20;
    empty_10     = e10;
    empty_5      = e5;
    coin_ack     = 1'($urandom_range(0, 1));

    k = 0; w = 0; finished = 1'b0;
    for (cnt = 0; cnt < 400 && !finished; cnt++) begin
      @(negedge clk);
      // Load attempts while busy must be ignored.
      change_valid = ($urandom_range(0, 3) == 0);
      change_amt   = WIDTH'($urandom);
      if (done) begin
        check("done_latency",   cnt,       exp_lat);
        check("shortfall",      shortfall, exp_short);
        check("fault",          fault,     exp_fault);
        check("coins_paid",     k,         paid);
        check("done_busy",      busy,      1);
        check("done_remaining", remaining, rem);
        if (exp_fault) check("req_cycles", w, TO);
        finished     = 1'b1;
        change_valid = 1'b0;
        coin_ack     = 1'b0;
        empty_20 = e20; empty_10 = e10; empty_5 = e5;
      end else if (coin_req) begin
        if (w == 0) begin
          if (k < codes.size()) begin
            check("coin_sel",  coin_sel,  codes[k]);
            check("remaining", remaining, rems[k]);
          end else begin
            check("extra_req", 1, 0);
          end
        end
        // Hopper status may wobble while a request is pending.
        empty_20 = 1'($urandom_range(0, 1));
        empty_10 = 1'($urandom_range(0, 1));
        empty_5  = 1'($urandom_range(0, 1));
        if (k < dly.size() && w == dly[k]) begin
          coin_ack = 1'b1;
          k++;
          w = 0;
        end else begin
          coin_ack = 1'b0;
          w++;
        end
      end else begin
        check("select_busy", busy, 1);
        coin_ack = 1'($urandom_range(0, 1));
        empty_20 = e20; empty_10 = e10; empty_5 = e5;
      end
    end
    if (!finished) check("done_timeout", 0, 1);

    @(negedge clk);
    change_valid = 1'b0;
    check("idle_busy",      busy,      0);
    check("idle_done",      done,      0);
    check("held_shortfall", shortfall, exp_short);
    check("held_fault",     fault,     exp_fault);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    run_txn(40, 0, 0, 0, 0);
    run_txn(35, 0, 0, 0, 0);
    run_txn(30, 1, 0, 0, 0);
    run_txn(7,  0, 0, 0, 0);
    run_txn(0,  0, 0, 0, 0);
    run_txn(20, 0, 0, 0, 2);
    run_txn(20, 0, 0, 0, 3);
    run_txn(25, 1, 1, 1, 0);
    run_txn(63, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 63)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), 1);
    end

    // Reset in the middle of a payout.
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = WIDTH'(40);
    empty_20 = 1'b0; empty_10 = 1'b0; empty_5 = 1'b0;
    coin_ack = 1'b0;
    @(negedge clk);
    change_valid = 1'b0;
    for (int i = 0; i < 10 && !coin_req; i++) @(negedge clk);
    check("rst_first_req", coin_req, 1);
    change_valid = 1'b1;
    change_amt   = WIDTH'(5);
    coin_ack     = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    coin_ack     = 1'b0;
    check("ignored_load", remaining, 20);
    @(negedge clk);
    check("rst_second_req", coin_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    repeat (5) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
